mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Round-robin arbiter sharing one single-port `memory` instance among `NUM_REQ` requesters. Each requester issues independent read/write commands with a valid/ready handshake. The arbiter grants one command per cycle, drives the memory's command port, and returns a one-cycle-latency response to the granted requester. A bounded lock mechanism lets one requester hold the port for back-to-back accesses.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `WIDTH`, 8: data width; matches the memory.
- `DEPTH`, 16: memory depth; matches the memory.
- `ADDR_WIDTH`, `$clog2(DEPTH)`: address width.
- `MAX_LOCK`, 8: maximum consecutive grants to one locked requester, ≥1.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `req_valid` in `NUM_REQ`: command valid, per requester.
- `req_wr` in `NUM_REQ`: 1 = write, 0 = read.
- `req_lock` in `NUM_REQ`: request to keep the grant next cycle.
- `req_addr` in `NUM_REQ*ADDR_WIDTH`: packed addresses; requester i occupies slice [i*ADDR_WIDTH +: ADDR_WIDTH].
- `req_wdata` in `NUM_REQ*WIDTH`: packed write data, same slicing.
- `req_ready` out `NUM_REQ`: one-hot grant. The command transfers when `req_valid[i]` and `req_ready[i]` are both high.
- `rsp_valid` out `NUM_REQ`: one-hot response strobe.
- `rsp_rdata` out `WIDTH`: read data; 0 for write acknowledges.
- `mem_valid`, `mem_wr_rd_en` out 1: memory command.
- `mem_addr` out `ADDR_WIDTH`; `mem_wdata` out `WIDTH`.
- `mem_rdata` in `WIDTH`; `mem_ready` in 1: from the memory.

## Operation
- **Grant selection:** combinational from `req_valid`, the registered `rr_ptr`, and the lock state.
  - Unlocked: the first requester with `req_valid` set is granted, searching from `rr_ptr` upward with wrap-around.
  - Locked: the lock owner is granted if its `req_valid` is set; otherwise the search proceeds as if unlocked.
  - No `req_valid` set: `req_ready` = 0 and `mem_valid` = 0.
- **Memory command:** on a grant to requester g, `mem_valid` = 1 and `mem_wr_rd_en`/`mem_addr`/`mem_wdata` = requester g's fields, in the same cycle. When there is no grant, all memory outputs are 0.
- **Pointer update:** after each transfer, `rr_ptr` ← (g+1) mod `NUM_REQ`. The pointer updates even under lock, so the first unlocked grant after a lock is fair.
- **Lock FSM, states UNLOCKED and LOCKED, with owner and `lock_cnt`:**
  - UNLOCKED → LOCKED on a transfer with `req_lock[g]` = 1. Owner = g, `lock_cnt` = 1.
  - LOCKED, transfer by the owner with `req_lock` = 1 and `lock_cnt` < `MAX_LOCK`: stay LOCKED, `lock_cnt`++.
  - LOCKED → UNLOCKED when any of these holds:
    - the owner transfers with `req_lock` = 0;
    - the owner's `req_valid` = 0 in a cycle;
    - `lock_cnt` = `MAX_LOCK` at a transfer (forced release).
  - Forced release: the next grant uses normal round-robin. The releasing transfer itself never re-locks.
  - `MAX_LOCK` = 1 makes locking a no-op.
- **Response stage:** registers `rsp_pend`, `rsp_id`, and `rsp_wr` from each transfer.
  - The cycle after a transfer, `rsp_valid[rsp_id]` = 1.
  - `rsp_rdata` = `mem_rdata` for a read, 0 for a write.
- **Ordering:** back-to-back transfers in consecutive cycles are supported. A read of an address written in the previous cycle returns the new data.
- **`mem_ready` check:** it is sampled only when `rsp_pend` = 1. If it is 0 there, that is a protocol error and the simulation assertion fires; responses are not gated by it.

## Timing
- **Reset values:** `req_ready` = 0, `rsp_valid` = 0, `rsp_rdata` = 0, all `mem_*` outputs = 0. `rr_ptr` = 0, state = UNLOCKED, `lock_cnt` = 0, `rsp_pend` = 0.
- **During reset:** grants are suppressed even if `req_valid` is high.
- **Reset mid-operation:** a pending response is dropped, with no `rsp_valid` in the cycle after reset deasserts. Requesters must reissue.
- **Grant latency:** 0 cycles. `req_ready` and `mem_valid` are combinational in the cycle of the request.
- **Response latency:** exactly 1 cycle after transfer, for both reads and writes.
- **Throughput:** one transfer per cycle total.
- **Worst-case wait for a requester that holds `req_valid`:** (`NUM_REQ`−1)·`MAX_LOCK` cycles.
- **Requester contract:** requesters hold their command stable until transfer. Dropping `req_valid` before transfer is allowed; the arbiter stores no state for that requester.

## Structure
- Package `mem_pkg`: `lock_state_e` (UNLOCKED, LOCKED) and the default `WIDTH`/`DEPTH` constants shared with `memory`.
- Sub-module `rr_arbiter`: purely combinational.
  - Inputs: request vector, pointer, optional forced owner.
  - Output: one-hot grant plus the encoded index.
- `mem_arbiter` owns the pointer, lock FSM, response register, and memory muxing.

## Test plan
- **Single read:** reset, then memory preloaded by writing 0x5A to addr 3 via requester 0. Requester 1 reads addr 3 → `rsp_valid` = 4'b0010 one cycle later, `rsp_rdata` = 0x5A.
- **Round-robin, all unlocked:** all four `req_valid` held → grants 0,1,2,3,0,… each cycle; `mem_valid` continuously 1.
- **Lock:** requester 2 holds `req_valid` and `req_lock` with `MAX_LOCK` = 8, others also requesting → 8 consecutive grants to requester 2, then requester 3, then 0.
- **Lock released by the owner:** requester 1 locks, deasserts `req_lock` on its third transfer → the next grant goes to requester 2.
- **Write then read, same address:** requester 0 writes 0xA5 to addr 15 in cycle t, requester 1 reads addr 15 in cycle t+1 → response at t+2 = 0xA5. The write acknowledge at t+1 has `rsp_rdata` = 0.
- **Reset mid-operation:** `reset` asserted in the cycle after a read transfer → no `rsp_valid`. After reset, all outputs are 0 and the next grant starts from requester 0.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared types and default geometry for the memory arbiter and the memory it fronts.
// The lock state enum is used by the arbiter's lock FSM.
package mem_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_DEPTH = 16;

  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } lock_state_e;

  // Successor of a requester index with wrap-around at num_req.
  function automatic int next_index(input int idx, input int num_req);
    return (idx + 1) % num_req;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of requester-side and memory-side signals around mem_arbiter.
// slave = the arbiter's view; master = requesters plus the memory.
interface mem_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int WIDTH      = mem_pkg::DEFAULT_WIDTH,
  parameter int ADDR_WIDTH = $clog2(mem_pkg::DEFAULT_DEPTH)
);

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_wr;
  logic [NUM_REQ-1:0]            req_lock;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ*WIDTH-1:0]      req_wdata;
  logic [NUM_REQ-1:0]            req_ready;

  logic [NUM_REQ-1:0]            rsp_valid;
  logic [WIDTH-1:0]              rsp_rdata;

  logic                          mem_valid;
  logic                          mem_wr_rd_en;
  logic [ADDR_WIDTH-1:0]         mem_addr;
  logic [WIDTH-1:0]              mem_wdata;
  logic [WIDTH-1:0]              mem_rdata;
  logic                          mem_ready;

  modport slave (
    input  req_valid, req_wr, req_lock, req_addr, req_wdata,
    input  mem_rdata, mem_ready,
    output req_ready, rsp_valid, rsp_rdata,
    output mem_valid, mem_wr_rd_en, mem_addr, mem_wdata
  );

  modport master (
    output req_valid, req_wr, req_lock, req_addr, req_wdata,
    output mem_rdata, mem_ready,
    input  req_ready, rsp_valid, rsp_rdata,
    input  mem_valid, mem_wr_rd_en, mem_addr, mem_wdata
  );

endinterface

// File: rtl/mem_arbiter_rr.sv
// Combinational round-robin grant: a valid forced owner wins, otherwise the first
// requester at or above ptr (wrapping) is granted.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  input  logic               force_en,
  input  logic [IDX_W-1:0]   force_id,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_id,
  output logic               grant_any
);

  int               idx;
  logic [IDX_W-1:0] sel;

  always_comb begin
    grant     = '0;
    grant_id  = '0;
    grant_any = 1'b0;
    idx       = 0;
    sel       = '0;
    if (force_en && req[force_id]) begin
      grant_any = 1'b1;
      grant_id  = force_id;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        idx = (int'(ptr) + i) % NUM_REQ;
        sel = IDX_W'(idx);
        if (!grant_any && req[sel]) begin
          grant_any = 1'b1;
          grant_id  = sel;
        end
      end
    end
    if (grant_any) begin
      grant[grant_id] = 1'b1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port memory among NUM_REQ requesters,
// with a bounded lock for back-to-back accesses and a one-cycle response stage.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int WIDTH      = DEFAULT_WIDTH,
  parameter int DEPTH      = DEFAULT_DEPTH,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int MAX_LOCK   = 8
) (
  input logic          clk,
  input logic          reset,
  mem_arbiter_if.slave bus
);

  localparam int IDX_W   = $clog2(NUM_REQ);
  localparam int CNT_W   = $clog2(MAX_LOCK + 1);
  localparam bit LOCK_EN = (MAX_LOCK > 1);

  lock_state_e        state, state_next;
  logic [IDX_W-1:0]   owner, owner_next;
  logic [CNT_W-1:0]   lock_cnt, lock_cnt_next;
  logic [IDX_W-1:0]   rr_ptr, rr_ptr_next;

  logic               rsp_pend;
  logic [IDX_W-1:0]   rsp_id;
  logic               rsp_wr;

  logic [NUM_REQ-1:0] req_eff;
  logic [NUM_REQ-1:0] grant;
  logic [IDX_W-1:0]   gid;
  logic               xfer;

  // Reset masks all requests so nothing is granted while it is held.
  assign req_eff = reset ? '0 : bus.req_valid;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr (
    .req       (req_eff),
    .ptr       (rr_ptr),
    .force_en  (state == LOCKED),
    .force_id  (owner),
    .grant     (grant),
    .grant_id  (gid),
    .grant_any (xfer)
  );

  assign bus.req_ready = grant;

  always_comb begin
    bus.mem_valid    = 1'b0;
    bus.mem_wr_rd_en = 1'b0;
    bus.mem_addr     = '0;
    bus.mem_wdata    = '0;
    if (xfer) begin
      bus.mem_valid    = 1'b1;
      bus.mem_wr_rd_en = bus.req_wr[gid];
      bus.mem_addr     = bus.req_addr[int'(gid)*ADDR_WIDTH +: ADDR_WIDTH];
      bus.mem_wdata    = bus.req_wdata[int'(gid)*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    rr_ptr_next = rr_ptr;
    if (xfer) begin
      rr_ptr_next = IDX_W'(next_index(int'(gid), NUM_REQ));
    end
  end

  // lock_cnt counts grants already taken under the lock, so the grant that
  // would make it reach MAX_LOCK is the releasing one.
  always_comb begin
    state_next    = state;
    owner_next    = owner;
    lock_cnt_next = lock_cnt;
    case (state)
      UNLOCKED: begin
        if (LOCK_EN && xfer && bus.req_lock[gid]) begin
          state_next    = LOCKED;
          owner_next    = gid;
          lock_cnt_next = CNT_W'(1);
        end
      end
      LOCKED: begin
        if (!req_eff[owner]) begin
          state_next    = UNLOCKED;
          lock_cnt_next = '0;
          if (xfer && bus.req_lock[gid]) begin
            state_next    = LOCKED;
            owner_next    = gid;
            lock_cnt_next = CNT_W'(1);
          end
        end else if (bus.req_lock[owner] && (int'(lock_cnt) + 1 < MAX_LOCK)) begin
          lock_cnt_next = lock_cnt + 1'b1;
        end else begin
          state_next    = UNLOCKED;
          lock_cnt_next = '0;
        end
      end
      default: begin
        state_next    = UNLOCKED;
        lock_cnt_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= UNLOCKED;
      owner    <= '0;
      lock_cnt <= '0;
      rr_ptr   <= '0;
      rsp_pend <= 1'b0;
      rsp_id   <= '0;
      rsp_wr   <= 1'b0;
    end else begin
      state    <= state_next;
      owner    <= owner_next;
      lock_cnt <= lock_cnt_next;
      rr_ptr   <= rr_ptr_next;
      rsp_pend <= xfer;
      rsp_id   <= gid;
      rsp_wr   <= bus.mem_wr_rd_en;
    end
  end

  // A response registered just before reset is dropped while reset is held.
  always_comb begin
    bus.rsp_valid = '0;
    bus.rsp_rdata = '0;
    if (rsp_pend && !reset) begin
      bus.rsp_valid[rsp_id] = 1'b1;
      if (!rsp_wr) begin
        bus.rsp_rdata = bus.mem_rdata;
      end
    end
  end

  mem_ready_during_rsp: assert property (@(posedge clk) disable iff (reset)
    rsp_pend |-> bus.mem_ready);

  mem_addr_in_range: assert property (@(posedge clk) disable iff (reset)
    bus.mem_valid |-> (int'(bus.mem_addr) < DEPTH));

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed grant sequences with a response
// scoreboard and a behavioural single-port memory with one-cycle read latency.
module tb_mem_arbiter;

  localparam int NUM_REQ    = 4;
  localparam int WIDTH      = 8;
  localparam int DEPTH      = 16;
  localparam int ADDR_WIDTH = 4;
  localparam int MAX_LOCK   = 8;

  typedef struct {
    int               id;
    logic [WIDTH-1:0] data;
  } rsp_t;

  logic clk = 1'b0;
  logic reset;

  mem_arbiter_if #(
    .NUM_REQ    (NUM_REQ),
    .WIDTH      (WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) bus ();

  mem_arbiter #(
    .NUM_REQ    (NUM_REQ),
    .WIDTH      (WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .MAX_LOCK   (MAX_LOCK)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  rsp_t                  exp_q[$];
  logic [WIDTH-1:0]      mem_array [DEPTH];
  logic [WIDTH-1:0]      ref_mem   [DEPTH];
  logic [NUM_REQ-1:0]    cmd_valid;
  logic [NUM_REQ-1:0]    cmd_wr;
  logic [NUM_REQ-1:0]    cmd_lock;
  logic [ADDR_WIDTH-1:0] cmd_addr  [NUM_REQ];
  logic [WIDTH-1:0]      cmd_wdata [NUM_REQ];
  int                    vectors     = 0;
  int                    miscompares = 0;

  // Behavioural memory: writes land at the edge, reads return data one cycle later.
  assign bus.mem_ready = 1'b1;

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_array[i] <= '0;
      bus.mem_rdata <= '0;
    end else begin
      if (bus.mem_valid && bus.mem_wr_rd_en) mem_array[bus.mem_addr] <= bus.mem_wdata;
      bus.mem_rdata <= (bus.mem_valid && !bus.mem_wr_rd_en) ? mem_array[bus.mem_addr] : '0;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, observed,
               expected, $time);
    end
  endtask

  task automatic clearCmds();
    cmd_valid = '0;
    cmd_wr    = '0;
    cmd_lock  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cmd_addr[i]  = '0;
      cmd_wdata[i] = '0;
    end
  endtask

  task automatic setCmd(input int i, input logic wr, input logic lock,
                        input logic [ADDR_WIDTH-1:0] a, input logic [WIDTH-1:0] d);
    cmd_valid[i] = 1'b1;
    cmd_wr[i]    = wr;
    cmd_lock[i]  = lock;
    cmd_addr[i]  = a;
    cmd_wdata[i] = d;
  endtask

  task automatic clearRefMem();
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
  endtask

  task automatic driveBus();
    bus.req_valid = cmd_valid;
    bus.req_wr    = cmd_wr;
    bus.req_lock  = cmd_lock;
    for (int i = 0; i < NUM_REQ; i++) begin
      bus.req_addr[i*ADDR_WIDTH +: ADDR_WIDTH] = cmd_addr[i];
      bus.req_wdata[i*WIDTH +: WIDTH]          = cmd_wdata[i];
    end
  endtask

  // One clock cycle: drive, check grant and memory command mid-cycle, check the
  // response due from the previous cycle, then queue this cycle's response.
  task automatic applyStimulus(input int exp_grant);
    logic [NUM_REQ-1:0] exp_ready;
    logic [NUM_REQ-1:0] exp_rsp;
    rsp_t               e;
    driveBus();
    #3;
    exp_ready = '0;
    if (exp_grant >= 0) exp_ready[exp_grant] = 1'b1;
    checkOutput("req_ready", 32'(bus.req_ready), 32'(exp_ready));
    checkOutput("mem_valid", 32'(bus.mem_valid), 32'(exp_grant >= 0));
    if (exp_grant >= 0) begin
      checkOutput("mem_wr", 32'(bus.mem_wr_rd_en), 32'(cmd_wr[exp_grant]));
      checkOutput("mem_addr", 32'(bus.mem_addr), 32'(cmd_addr[exp_grant]));
      checkOutput("mem_wdata", 32'(bus.mem_wdata), 32'(cmd_wdata[exp_grant]));
    end else begin
      checkOutput("mem_idle", 32'({bus.mem_wr_rd_en, bus.mem_addr, bus.mem_wdata}), 32'(0));
    end
    if (exp_q.size() > 0) begin
      e       = exp_q.pop_front();
      exp_rsp = '0;
      exp_rsp[e.id] = 1'b1;
      checkOutput("rsp_valid", 32'(bus.rsp_valid), 32'(exp_rsp));
      checkOutput("rsp_rdata", 32'(bus.rsp_rdata), 32'(e.data));
    end else begin
      checkOutput("rsp_idle", 32'(bus.rsp_valid), 32'(0));
      checkOutput("rsp_rdata_idle", 32'(bus.rsp_rdata), 32'(0));
    end
    if (exp_grant >= 0) begin
      e.id   = exp_grant;
      e.data = cmd_wr[exp_grant] ? '0 : ref_mem[cmd_addr[exp_grant]];
      exp_q.push_back(e);
      if (cmd_wr[exp_grant]) ref_mem[cmd_addr[exp_grant]] = cmd_wdata[exp_grant];
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    clearRefMem();
    clearCmds();
    for (int i = 0; i < NUM_REQ; i++) setCmd(i, 1'b0, 1'b0, ADDR_WIDTH'(i), '0);
    driveBus();
    @(posedge clk);
    #1;

    $display("[TB] reset: grants suppressed while requests are held");
    applyStimulus(-1);
    applyStimulus(-1);
    reset = 1'b0;
    clearCmds();
    applyStimulus(-1);

    $display("[TB] single read after preload");
    setCmd(0, 1'b1, 1'b0, 4'd3, 8'h5A);
    applyStimulus(0);
    clearCmds();
    setCmd(1, 1'b0, 1'b0, 4'd3, '0);
    applyStimulus(1);
    clearCmds();
    applyStimulus(-1);

    $display("[TB] round-robin, all requesters writing");
    for (int i = 0; i < NUM_REQ; i++)
      setCmd(i, 1'b1, 1'b0, ADDR_WIDTH'(4 + i), WIDTH'(16 * (i + 1) + i));
    for (int k = 0; k < 8; k++) applyStimulus((2 + k) % NUM_REQ);
    clearCmds();
    applyStimulus(-1);

    $display("[TB] lock held to the limit by requester 2");
    for (int i = 0; i < NUM_REQ; i++)
      setCmd(i, 1'b0, (i == 2), ADDR_WIDTH'(4 + i), '0);
    for (int k = 0; k < MAX_LOCK; k++) applyStimulus(2);
    applyStimulus(3);
    applyStimulus(0);
    clearCmds();
    applyStimulus(-1);

    $display("[TB] lock released by owner 1");
    for (int i = 0; i < NUM_REQ; i++)
      setCmd(i, 1'b0, (i == 1), ADDR_WIDTH'(4 + i), '0);
    applyStimulus(1);
    applyStimulus(1);
    cmd_lock[1] = 1'b0;
    applyStimulus(1);
    applyStimulus(2);
    clearCmds();
    applyStimulus(-1);

    $display("[TB] write then read of the same address");
    setCmd(0, 1'b1, 1'b0, 4'd15, 8'hA5);
    applyStimulus(0);
    clearCmds();
    setCmd(1, 1'b0, 1'b0, 4'd15, '0);
    applyStimulus(1);
    clearCmds();
    applyStimulus(-1);

    $display("[TB] reset right after a read transfer");
    setCmd(3, 1'b0, 1'b0, 4'd6, '0);
    applyStimulus(3);
    reset = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) setCmd(i, 1'b0, 1'b0, ADDR_WIDTH'(i), '0);
    exp_q.delete();
    clearRefMem();
    applyStimulus(-1);
    reset = 1'b0;
    clearCmds();
    applyStimulus(-1);

    $display("[TB] lock dropped when owner withdraws its request");
    for (int i = 0; i < NUM_REQ; i++)
      setCmd(i, 1'b0, (i == 0), ADDR_WIDTH'(8 + i), '0);
    applyStimulus(0);
    cmd_valid[0] = 1'b0;
    applyStimulus(1);
    cmd_valid[0] = 1'b1;
    cmd_lock[0]  = 1'b0;
    applyStimulus(2);
    clearCmds();
    applyStimulus(-1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
